pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameters (name, default, meaning): REG_ADDR_W, 5, register address width.
REQ-002 MEM_LATENCY, 0, extra wait cycles per data-memory access (0..15).
REQ-003 FWD_EN, 1, 1 = forwarding mode, 0 = stall-only mode.
REQ-004 One clock; reset is asynchronous and active-high. Ports are listed below as name, direction, width, meaning.
REQ-005 clk  in  1  clock, rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 id_valid  in  1  IF/ID holds a real instruction.
REQ-008 id_rs1, id_rs2, id_rd  in  REG_ADDR_W each  register fields of the instruction in ID.
REQ-009 id_use_rs1, id_use_rs2, id_reg_wr, id_is_load, id_is_mem  in  1 each  ID decode flags.
REQ-010 ex_branch_taken  in  1  branch/jump in EX redirects the PC.
REQ-011 pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage register write enables.
REQ-012 if_id_flush, id_ex_flush  out  1 each  load a bubble (valid=0) into that stage register.
REQ-013 pc_redirect  out  1  PC loads the branch target this cycle.
REQ-014 fwd_a_sel, fwd_b_sel  out  2 each  EX operand source: 0 = regfile, 1 = EX/MEM ALU, 2 = MEM/WB result.
REQ-015 ex_valid, mem_valid, wb_valid  out  1 each  stage-valid bits.
REQ-016 wb_wr_en  out  1  regfile write qualifier (wb_valid AND WB reg_wr AND WB rd!=0).

Function
REQ-017 The block shall keep internal shadow registers {valid, rs1, rs2, use_rs1/2, rd, reg_wr, is_load, is_mem} for EX, MEM and WB, advancing with the stage enables.
REQ-018 The block shall operate a 2-state FSM: RUN and MEM_WAIT, with RUN as the reset state.
REQ-019 RUN->MEM_WAIT when MEM_LATENCY>0 and mem_valid and the MEM-stage is_mem flag is set on entry of that instruction into MEM; the wait counter is loaded with MEM_LATENCY.
REQ-020 In MEM_WAIT, all enables shall be 0, flushes 0, pc_redirect 0, and the counter decrements each cycle; at counter==1 the next state is RUN and the pipeline advances the following cycle.
REQ-021 The memory wait shall have top priority; ex_branch_taken is ignored in MEM_WAIT and honoured once RUN resumes.
REQ-022 Branch (RUN, ex_valid and ex_branch_taken): pc_redirect=1, if_id_flush=1, id_ex_flush=1, all enables 1; this outranks any load-use stall.
REQ-023 A hazard exists when id_valid and a used ID source (use_rsN and rsN!=0) equals the rd of a valid reg_wr stage S.
REQ-024 FWD_EN=1: stall only when S=EX and EX is_load (load-use), for exactly 1 cycle.
REQ-025 FWD_EN=0: stall on any hazard in EX, MEM or WB until it clears.
REQ-026 Stall: pc_en=0, if_id_en=0, id_ex_flush=1, id_ex_en=1, ex_mem_en=1, mem_wb_en=1.
REQ-027 Forwarding (FWD_EN=1) for each EX source with rsN!=0: select 1 if MEM valid, reg_wr and rd match; else 2 if WB matches; else 0. MEM outranks WB.
REQ-028 FWD_EN=0: fwd_a_sel = fwd_b_sel = 0 always.
REQ-029 x0 shall never cause a hazard or a forward.
REQ-030 Outputs other than the valid bits shall be combinational from the current state and shadows; there is no added latency.

Reset
REQ-031 While rst is high: state RUN, counter 0, and every shadow valid = 0 (ex_valid, mem_valid, wb_valid, wb_wr_en = 0); enables = 1, flushes = 0, fwd sels = 0.
REQ-032 Reset asserted mid-MEM_WAIT or mid-stall shall abort immediately; the first cycle after release is a normal RUN cycle.

Verification
REQ-033 add x1 in EX, then sub x2,x1,x3 in ID -> next cycle fwd_a_sel=1; a cycle later with x1 in WB -> fwd_a_sel=2; no stall.
REQ-034 lw x5 in EX, add using x5 in ID -> exactly 1 cycle of pc_en=0 and id_ex_flush=1, then fwd_a_sel=2.
REQ-035 ex_branch_taken with a load-use hazard in the same cycle -> pc_redirect=1 and both flushes=1, no stall; ex_valid=0 next cycle.
REQ-036 MEM_LATENCY=3, sw enters MEM -> 3 cycles with all enables 0, then resume; a branch asserted during the wait is redirected only after the wait.
REQ-037 FWD_EN=0, add x1 followed by a dependent instruction -> 3 stall cycles until x1 leaves WB; fwd sels stay 0.
REQ-038 Hazards involving x0 (rd=0 or rs=0) -> no stall, sel=0; rst pulsed during MEM_WAIT -> all valids 0 with no glitch on the enables after release.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard and stage-enable controller for a 5-stage in-order pipeline.
//   It tracks the EX/MEM/WB contents in shadow registers. From these it
//   produces the stage register enables, the bubble flushes, the PC redirect,
//   the EX operand forwarding selects and the regfile write qualifier.
//
// Ports
//   clk, rst                      clock (rising edge), async active-high reset
//   id_valid, id_rs1/rs2/rd       instruction currently held in IF/ID
//   id_use_rs1/2, id_reg_wr,
//   id_is_load, id_is_mem         ID decode flags
//   ex_branch_taken               branch/jump in EX redirects the PC
//   pc_en .. mem_wb_en            stage register write enables
//   if_id_flush, id_ex_flush      load a bubble into that stage register
//   pc_redirect                   PC loads the branch target this cycle
//   fwd_a_sel, fwd_b_sel          0 = regfile, 1 = EX/MEM ALU, 2 = MEM/WB
//   ex_valid, mem_valid, wb_valid stage-valid bits
//   wb_wr_en                      regfile write qualifier
//
// state       | meaning
// ST_RUN      | pipeline flows; branch / stall / forwarding decisions active
// ST_MEM_WAIT | data memory access in MEM is pending; whole pipeline frozen
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_LATENCY = 0,
  parameter int FWD_EN      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  id_reg_wr,
  input  logic                  id_is_load,
  input  logic                  id_is_mem,
  input  logic                  ex_branch_taken,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  pc_redirect,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  ex_valid,
  output logic                  mem_valid,
  output logic                  wb_valid,
  output logic                  wb_wr_en
);

  typedef enum logic {ST_RUN, ST_MEM_WAIT} state_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  use_rs1;
    logic                  use_rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_wr;
    logic                  is_load;
    logic                  is_mem;
  } stage_t;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  stage_t     ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  stage_t     id_s;

  logic haz_ex, haz_mem, haz_wb, stall;

  // ID source s matches the destination of a valid writing stage; x0 never matches.
  function automatic logic src_hit(input stage_t s,
                                   input logic use_r,
                                   input logic [REG_ADDR_W-1:0] rs);
    return use_r && (rs != '0) && s.valid && s.reg_wr && (s.rd == rs);
  endfunction

  function automatic logic stage_hazard(input stage_t s);
    return id_valid && (src_hit(s, id_use_rs1, id_rs1) || src_hit(s, id_use_rs2, id_rs2));
  endfunction

  // MEM outranks WB because it holds the younger result.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                         input stage_t m,
                                         input stage_t w);
    if (rs == '0)                              return 2'd0;
    else if (m.valid && m.reg_wr && m.rd == rs) return 2'd1;
    else if (w.valid && w.reg_wr && w.rd == rs) return 2'd2;
    else                                       return 2'd0;
  endfunction

  always_comb begin
    id_s         = '0;
    id_s.valid   = id_valid;
    id_s.rs1     = id_rs1;
    id_s.rs2     = id_rs2;
    id_s.use_rs1 = id_use_rs1;
    id_s.use_rs2 = id_use_rs2;
    id_s.rd      = id_rd;
    id_s.reg_wr  = id_reg_wr;
    id_s.is_load = id_is_load;
    id_s.is_mem  = id_is_mem;
  end

  assign haz_ex  = stage_hazard(ex_q);
  assign haz_mem = stage_hazard(mem_q);
  assign haz_wb  = stage_hazard(wb_q);
  assign stall   = (FWD_EN != 0) ? (haz_ex && ex_q.is_load)
                                 : (haz_ex || haz_mem || haz_wb);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pc_redirect = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (ex_q.valid && ex_branch_taken) begin
          pc_redirect = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (stall) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
        mem_wb_en = 1'b0;
        cnt_d     = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    ex_d = ex_q;
    if (id_ex_en) begin
      ex_d = id_ex_flush ? '0 : id_s;
    end
    mem_d = ex_mem_en ? ex_q : mem_q;
    wb_d  = mem_wb_en ? mem_q : wb_q;

    // The wait starts on the edge that moves the access into MEM, so the
    // instruction is frozen there for the full latency and is not re-armed
    // once the pipeline resumes.
    if ((state_q == ST_RUN) && (MEM_LATENCY > 0) && mem_d.valid && mem_d.is_mem) begin
      state_d = ST_MEM_WAIT;
      cnt_d   = LAT_LOAD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
    end
  end

  assign fwd_a_sel = (FWD_EN != 0) ? fwd_sel(ex_q.rs1, mem_q, wb_q) : 2'd0;
  assign fwd_b_sel = (FWD_EN != 0) ? fwd_sel(ex_q.rs2, mem_q, wb_q) : 2'd0;

  assign ex_valid  = ex_q.valid;
  assign mem_valid = mem_q.valid;
  assign wb_valid  = wb_q.valid;
  assign wb_wr_en  = wb_q.valid && wb_q.reg_wr && (wb_q.rd != '0);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl. Three instances: 0 = forwarding, no memory
// latency; 1 = forwarding, MEM_LATENCY=3; 2 = stall-only. Expected output
// vectors are queued when a cycle's stimulus is driven and popped when the
// outputs are sampled.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       u1;
    logic       u2;
    logic       wr;
    logic       ld;
    logic       mem;
    logic       br;
  } stim_t;

  localparam stim_t      NOP_S    = '0;
  localparam logic [4:0] EN_ALL   = 5'b11111;
  localparam logic [4:0] EN_STALL = 5'b00111;
  localparam logic [4:0] EN_NONE  = 5'b00000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  stim_t       stim [3];
  logic [15:0] obs  [3];
  logic [15:0] exp_q [$];
  int          n_checks = 0;
  int          n_err    = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 1) ? 3 : 0;
    localparam int FWD = (g == 2) ? 0 : 1;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_flush, pc_redirect;
    logic [1:0] fa, fb;
    logic       exv, memv, wbv, wbwr;

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .MEM_LATENCY(LAT), .FWD_EN(FWD)) u_dut (
      .clk             (clk),
      .rst             (rst),
      .id_valid        (stim[g].v),
      .id_rs1          (stim[g].rs1),
      .id_rs2          (stim[g].rs2),
      .id_rd           (stim[g].rd),
      .id_use_rs1      (stim[g].u1),
      .id_use_rs2      (stim[g].u2),
      .id_reg_wr       (stim[g].wr),
      .id_is_load      (stim[g].ld),
      .id_is_mem       (stim[g].mem),
      .ex_branch_taken (stim[g].br),
      .pc_en           (pc_en),
      .if_id_en        (if_id_en),
      .id_ex_en        (id_ex_en),
      .ex_mem_en       (ex_mem_en),
      .mem_wb_en       (mem_wb_en),
      .if_id_flush     (if_id_flush),
      .id_ex_flush     (id_ex_flush),
      .pc_redirect     (pc_redirect),
      .fwd_a_sel       (fa),
      .fwd_b_sel       (fb),
      .ex_valid        (exv),
      .mem_valid       (memv),
      .wb_valid        (wbv),
      .wb_wr_en        (wbwr)
    );

    assign obs[g] = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                     if_id_flush, id_ex_flush, pc_redirect, fa, fb,
                     exv, memv, wbv, wbwr};
  end

  function automatic logic [15:0] ev(input logic [4:0] en, input logic [1:0] fl,
                                     input logic rd, input logic [1:0] fa,
                                     input logic [1:0] fb, input logic [2:0] v,
                                     input logic w);
    return {en, fl, rd, fa, fb, v, w};
  endfunction

  function automatic stim_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    stim_t s = '0;
    s.v = 1'b1; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2;
    s.u1 = 1'b1; s.u2 = 1'b1; s.wr = 1'b1;
    return s;
  endfunction

  function automatic stim_t lw(input logic [4:0] rd, input logic [4:0] rs1);
    stim_t s = '0;
    s.v = 1'b1; s.rd = rd; s.rs1 = rs1;
    s.u1 = 1'b1; s.wr = 1'b1; s.ld = 1'b1; s.mem = 1'b1;
    return s;
  endfunction

  function automatic stim_t sw(input logic [4:0] rs1, input logic [4:0] rs2);
    stim_t s = '0;
    s.v = 1'b1; s.rs1 = rs1; s.rs2 = rs2;
    s.u1 = 1'b1; s.u2 = 1'b1; s.mem = 1'b1;
    return s;
  endfunction

  function automatic stim_t with_br(input stim_t s);
    stim_t r = s;
    r.br = 1'b1;
    return r;
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%b want=%b", tag, got, want);
    end
  endtask

  // One clock cycle on instance k: drive, queue the expectation, sample.
  task automatic cyc(input int k, input stim_t s, input logic r,
                     input logic [15:0] e, input string tag);
    logic [15:0] want;
    @(negedge clk);
    for (int i = 0; i < 3; i++) stim[i] = (i == k) ? s : NOP_S;
    rst = r;
    exp_q.push_back(e);
    #2;
    want = exp_q.pop_front();
    check(tag, obs[k], want);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) stim[i] = NOP_S;

    // reset state on every configuration
    cyc(0, NOP_S, 1'b1, ev(EN_ALL, 2'b00, 0, 0, 0, 3'b000, 0), "rst0");
    cyc(1, NOP_S, 1'b1, ev(EN_ALL, 2'b00, 0, 0, 0, 3'b000, 0), "rst1");
    cyc(2, NOP_S, 1'b1, ev(EN_ALL, 2'b00, 0, 0, 0, 3'b000, 0), "rst2");

    // forwarding from MEM then WB, no stall
    cyc(0, alu(5'd1, 5'd4, 5'd5), 1'b0, ev(EN_ALL, 2'b00, 0, 0, 0, 3'b000, 0), "fw_c0");
    cyc(0, alu(5'd2, 5'd1, 5'd3), 1'b0, ev(EN_ALL, 2'b00, 0, 0, 0, 3'b100, 0), "fw_c1");
    cyc(0, alu(5'd6, 5'd1, 5'd7), 1'b0, ev(EN_ALL, 2'b00, 0, 1, 0, 3'b110, 0), "fw_mem");
    cyc(0, NOP_S,                 1'b0, ev(EN_ALL, 2'b00, 0, 2, 0, 3'b111, 1), "fw_wb");
    cyc(0, NOP_S,                 1'b0, ev(EN_ALL, 2'b00, 0, 0, 0, 3'b011, 1), "fw_c4");
    cyc(0, NOP_S,                 1'b0, ev(EN_ALL, 2'b00, 0, 0, 0, 3'b001, 1), "fw_c5");
    cyc(0, NOP_S,                 1'b0, ev(EN_ALL, 2'b00, 0, 0, 0, 3'b000, 0), "fw_c6");

    // MEM outranks WB when both write the same register
    cyc(0, alu(5'd1, 5'd4, 5'd5), 1'b0, ev(EN_ALL, 2'b00, 0, 0, 0, 3'b000, 0), "pri_c0");
    cyc(0, alu(5'd1, 5'd1, 5'd1), 1'b0, ev(EN_ALL, 2'b00, 0, 0, 0, 3'b100, 0), "pri_c1");
    cyc(0, alu(5'd3, 5'd1, 5'd1), 1'b0, ev(EN_ALL, 2'b00, 0, 1, 1, 3'b110, 0), "pri_c2");
    cyc(0, NOP_S,                 1'b0, ev(EN_ALL, 2'b00, 0, 1, 1, 3'b111, 1), "pri_memwb");
    cyc(0, NOP_S,                 1'b0, ev(EN_ALL, 2'b00, 0, 0, 0, 3'b011, 1), "pri_c4");
    cyc(0, NOP_S,                 1'b0, ev(EN_ALL, 2'b00, 0, 0, 0, 3'b001, 1), "pri_c5");
    cyc(0, NOP_S,                 1'b0, ev(EN_ALL, 2'b00, 0, 0, 0, 3'b000, 0), "pri_c6");

    // load-use: one stall cycle, then WB forward
    cyc(0, lw(5'd5, 5'd8),         1'b0, ev(EN_ALL,   2'b00, 0, 0, 0, 3'b000, 0), "lu_c0");
    cyc(0, alu(5'd9, 5'd5, 5'd10), 1'b0, ev(EN_STALL, 2'b01, 0, 0, 0, 3'b100, 0), "lu_stall");
    cyc(0, alu(5'd9, 5'd5, 5'd10), 1'b0, ev(EN_ALL,   2'b00, 0, 0, 0, 3'b010, 0), "lu_go");
    cyc(0, NOP_S,                  1'b0, ev(EN_ALL,   2'b00, 0, 2, 0, 3'b101, 1), "lu_fwd");
    cyc(0, NOP_S,                  1'b0, ev(EN_ALL,   2'b00, 0, 0, 0, 3'b010, 0), "lu_c4");
    cyc(0, NOP_S,                  1'b0, ev(EN_ALL,   2'b00, 0, 0, 0, 3'b001, 1), "lu_c5");
    cyc(0, NOP_S,                  1'b0, ev(EN_ALL,   2'b00, 0, 0, 0, 3'b000, 0), "lu_c6");

    // branch outranks load-use; branch with empty EX ignored
    cyc(0, lw(5'd5, 5'd8),                  1'b0, ev(EN_ALL, 2'b00, 0, 0, 0, 3'b000, 0), "br_c0");
    cyc(0, with_br(alu(5'd9, 5'd5, 5'd10)), 1'b0, ev(EN_ALL, 2'b11, 1, 0, 0, 3'b100, 0), "br_take");
    cyc(0, with_br(NOP_S),                  1'b0, ev(EN_ALL, 2'b00, 0, 0, 0, 3'b010, 0), "br_exinv");
    cyc(0, NOP_S,                           1'b0, ev(EN_ALL, 2'b00, 0, 0, 0, 3'b001, 1), "br_c3");
    cyc(0, NOP_S,                           1'b0, ev(EN_ALL, 2'b00, 0, 0, 0, 3'b000, 0), "br_c4");

    // x0 never hazards or forwards; WB write to x0 is not qualified
    cyc(0, lw(5'd0, 5'd8),        1'b0, ev(EN_ALL, 2'b00, 0, 0, 0, 3'b000, 0), "x0_c0");
    cyc(0, alu(5'd9, 5'd0, 5'd0), 1'b0, ev(EN_ALL, 2'b00, 0, 0, 0, 3'b100, 0), "x0_nostall");
    cyc(0, NOP_S,                 1'b0, ev(EN_ALL, 2'b00, 0, 0, 0, 3'b110, 0), "x0_nofwd");
    cyc(0, NOP_S,                 1'b0, ev(EN_ALL, 2'b00, 0, 0, 0, 3'b011, 0), "x0_wbwr");
    cyc(0, NOP_S,                 1'b0, ev(EN_ALL, 2'b00, 0, 0, 0, 3'b001, 1), "x0_c4");
    cyc(0, NOP_S,                 1'b0, ev(EN_ALL, 2'b00, 0, 0, 0, 3'b000, 0), "x0_c5");

    // MEM_LATENCY=3: store freezes the pipe, branch waits for RUN
    cyc(1, sw(5'd8, 5'd9),         1'b0, ev(EN_ALL,  2'b00, 0, 0, 0, 3'b000, 0), "mw_c0");
    cyc(1, alu(5'd1, 5'd4, 5'd5),  1'b0, ev(EN_ALL,  2'b00, 0, 0, 0, 3'b100, 0), "mw_c1");
    cyc(1, with_br(NOP_S),         1'b0, ev(EN_NONE, 2'b00, 0, 0, 0, 3'b110, 0), "mw_w1");
    cyc(1, with_br(NOP_S),         1'b0, ev(EN_NONE, 2'b00, 0, 0, 0, 3'b110, 0), "mw_w2");
    cyc(1, with_br(NOP_S),         1'b0, ev(EN_NONE, 2'b00, 0, 0, 0, 3'b110, 0), "mw_w3");
    cyc(1, with_br(NOP_S),         1'b0, ev(EN_ALL,  2'b11, 1, 0, 0, 3'b110, 0), "mw_br");
    cyc(1, NOP_S,                  1'b0, ev(EN_ALL,  2'b00, 0, 0, 0, 3'b011, 0), "mw_c6");
    cyc(1, NOP_S,                  1'b0, ev(EN_ALL,  2'b00, 0, 0, 0, 3'b001, 1), "mw_c7");
    cyc(1, NOP_S,                  1'b0, ev(EN_ALL,  2'b00, 0, 0, 0, 3'b000, 0), "mw_c8");

    // reset pulsed during MEM_WAIT
    cyc(1, sw(5'd8, 5'd9),        1'b0, ev(EN_ALL,  2'b00, 0, 0, 0, 3'b000, 0), "rw_c0");
    cyc(1, NOP_S,                 1'b0, ev(EN_ALL,  2'b00, 0, 0, 0, 3'b100, 0), "rw_c1");
    cyc(1, NOP_S,                 1'b0, ev(EN_NONE, 2'b00, 0, 0, 0, 3'b010, 0), "rw_wait");
    cyc(1, NOP_S,                 1'b1, ev(EN_ALL,  2'b00, 0, 0, 0, 3'b000, 0), "rw_rst");
    cyc(1, NOP_S,                 1'b0, ev(EN_ALL,  2'b00, 0, 0, 0, 3'b000, 0), "rw_rel");
    cyc(1, alu(5'd3, 5'd4, 5'd5), 1'b0, ev(EN_ALL,  2'b00, 0, 0, 0, 3'b000, 0), "rw_c5");
    cyc(1, NOP_S,                 1'b0, ev(EN_ALL,  2'b00, 0, 0, 0, 3'b100, 0), "rw_c6");

    // stall-only: stall until x1 leaves WB, sels stay 0
    cyc(2, alu(5'd1, 5'd4, 5'd5), 1'b0, ev(EN_ALL,   2'b00, 0, 0, 0, 3'b000, 0), "so_c0");
    cyc(2, alu(5'd2, 5'd1, 5'd3), 1'b0, ev(EN_STALL, 2'b01, 0, 0, 0, 3'b100, 0), "so_s_ex");
    cyc(2, alu(5'd2, 5'd1, 5'd3), 1'b0, ev(EN_STALL, 2'b01, 0, 0, 0, 3'b010, 0), "so_s_mem");
    cyc(2, alu(5'd2, 5'd1, 5'd3), 1'b0, ev(EN_STALL, 2'b01, 0, 0, 0, 3'b001, 1), "so_s_wb");
    cyc(2, alu(5'd2, 5'd1, 5'd3), 1'b0, ev(EN_ALL,   2'b00, 0, 0, 0, 3'b000, 0), "so_go");
    cyc(2, NOP_S,                 1'b0, ev(EN_ALL,   2'b00, 0, 0, 0, 3'b100, 0), "so_nofwd");
    cyc(2, NOP_S,                 1'b0, ev(EN_ALL,   2'b00, 0, 0, 0, 3'b010, 0), "so_c6");
    cyc(2, NOP_S,                 1'b0, ev(EN_ALL,   2'b00, 0, 0, 0, 3'b001, 1), "so_c7");
    cyc(2, NOP_S,                 1'b0, ev(EN_ALL,   2'b00, 0, 0, 0, 3'b000, 0), "so_c8");

    // stall-only with x0 operands: no stall
    cyc(2, alu(5'd0, 5'd4, 5'd5), 1'b0, ev(EN_ALL, 2'b00, 0, 0, 0, 3'b000, 0), "sx0_c0");
    cyc(2, alu(5'd9, 5'd0, 5'd0), 1'b0, ev(EN_ALL, 2'b00, 0, 0, 0, 3'b100, 0), "sx0_nostall");
    cyc(2, NOP_S,                 1'b0, ev(EN_ALL, 2'b00, 0, 0, 0, 3'b110, 0), "sx0_c2");
    cyc(2, NOP_S,                 1'b0, ev(EN_ALL, 2'b00, 0, 0, 0, 3'b011, 0), "sx0_c3");
    cyc(2, NOP_S,                 1'b0, ev(EN_ALL, 2'b00, 0, 0, 0, 3'b001, 1), "sx0_c4");

    // reset pulsed during a stall
    cyc(2, alu(5'd1, 5'd4, 5'd5), 1'b0, ev(EN_ALL,   2'b00, 0, 0, 0, 3'b000, 0), "rs_c0");
    cyc(2, alu(5'd2, 5'd1, 5'd3), 1'b0, ev(EN_STALL, 2'b01, 0, 0, 0, 3'b100, 0), "rs_stall");
    cyc(2, alu(5'd2, 5'd1, 5'd3), 1'b1, ev(EN_ALL,   2'b00, 0, 0, 0, 3'b000, 0), "rs_rst");
    cyc(2, NOP_S,                 1'b0, ev(EN_ALL,   2'b00, 0, 0, 0, 3'b000, 0), "rs_rel");
    cyc(2, NOP_S,                 1'b0, ev(EN_ALL,   2'b00, 0, 0, 0, 3'b000, 0), "rs_c4");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
